// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port 32-bit data memory that answers core
// requests after a fixed number of wait states. Writes merge byte lanes
// little-endian; misaligned halfword/word writes are rejected with data_err_o.
// Optional build macro: DMEM_LLSC_EN adds a load-linked/store-conditional
// reservation (one word). Without it mem_fc_i/mem_sc_i are ignored.
//
// state | meaning
// IDLE  | waiting for a request; captures it and loads the wait counter
// WAIT  | counting down wait states; inputs ignored
// RESP  | commits the write / samples the read word; outputs register here
module data_mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_data_i,
    input  logic [1:0]  data_sel_i,
    input  logic        data_we_i,
    input  logic        data_rd_i,
    input  logic        mem_fc_i,
    input  logic        mem_sc_i,
    output logic [31:0] data_data_o,
    output logic        data_valid_o,
    output logic        data_err_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 req;
    logic                 capture;
    logic [ADDR_BITS-1:0] idx_q;
    logic [1:0]           lane_q;
    logic [1:0]           sel_q;
    logic [31:0]          wdata_q;
    logic                 we_q;
    logic [31:0]          mem [2**ADDR_BITS];
    logic [31:0]          cur_word;
    logic [31:0]          merged_word;
    logic [31:0]          wr_status;
    logic [3:0]           byte_en;
    logic                 misaligned;
    logic                 sc_ok;
    logic                 commit;
    logic                 unused_addr;

    // Upper address bits beyond the array are deliberately ignored.
    assign unused_addr = ^data_addr_i[31:ADDR_BITS+2];

    assign req      = data_rd_i | data_we_i;
    assign cur_word = mem[idx_q];
    assign commit   = (state_q == ST_RESP) && we_q && !misaligned && sc_ok;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; only these copies are used after IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            lane_q  <= 2'b00;
            sel_q   <= 2'b00;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else if (capture) begin
            idx_q   <= data_addr_i[ADDR_BITS+1:2];
            lane_q  <= data_addr_i[1:0];
            sel_q   <= data_sel_i;
            wdata_q <= data_data_i;
            we_q    <= data_we_i;
        end
    end

    // Byte-enable decode and alignment check for the captured write.
    always_comb begin
        byte_en    = 4'b0000;
        misaligned = 1'b0;
        case (sel_q)
            2'b01: begin
                if (lane_q[0]) misaligned = 1'b1;
                else           byte_en    = lane_q[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                byte_en = 4'b0001 << lane_q;
            end
            default: begin
                if (lane_q != 2'b00) misaligned = 1'b1;
                else                 byte_en    = 4'b1111;
            end
        endcase
    end

    // Merge enabled write lanes over the current word.
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) merged_word[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

`ifdef DMEM_LLSC_EN
    logic                 fc_q;
    logic                 sc_q;
    logic                 res_valid_q;
    logic [ADDR_BITS-1:0] res_idx_q;

    assign sc_ok     = !sc_q || (res_valid_q && (res_idx_q == idx_q));
    assign wr_status = sc_q ? {31'd0, commit} : 32'd1;

    // Capture the LL/SC qualifiers alongside the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fc_q <= 1'b0;
            sc_q <= 1'b0;
        end else if (capture) begin
            fc_q <= mem_fc_i;
            sc_q <= mem_sc_i;
        end
    end

    // Reservation: set by LL reads, dropped by any SC or a store to the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
        end else if (state_q == ST_RESP) begin
            if (!we_q && fc_q) begin
                res_valid_q <= 1'b1;
                res_idx_q   <= idx_q;
            end else if (we_q && (sc_q || (commit && (res_idx_q == idx_q)))) begin
                res_valid_q <= 1'b0;
            end
        end
    end
`else
    logic unused_llsc;

    assign unused_llsc = mem_fc_i ^ mem_sc_i;
    assign sc_ok       = 1'b1;
    assign wr_status   = 32'd1;
`endif

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) mem[idx_q] <= merged_word;
    end

    // Response registers: one-cycle valid/err pulse, data held until next RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid_o <= 1'b0;
            data_err_o   <= 1'b0;
            data_data_o  <= 32'd0;
        end else if (state_q == ST_RESP) begin
            data_valid_o <= 1'b1;
            data_err_o   <= we_q && misaligned;
            data_data_o  <= we_q ? wr_status : cur_word;
        end else begin
            data_valid_o <= 1'b0;
            data_err_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 instance driven through
// directed accesses, and a WAIT_CYCLES=0 instance driven with a held request.
// A word-level memory model predicts each response and its cycle; one
// negedge process compares both instances against the predictions.
module tb_data_mem_responder;
    localparam int AB = 10;
    localparam int W2 = 2;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  sel = '0;
    logic        we = 1'b0, rd = 1'b0, fc = 1'b0, sc = 1'b0;
    logic [31:0] rdata;
    logic        valid, err;

    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [1:0]  sel0 = '0;
    logic        we0 = 1'b0, rd0 = 1'b0, tie0 = 1'b0;
    logic [31:0] rdata0;
    logic        valid0, err0;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        q2[$];
    exp_t        q0[$];
    logic [31:0] hold2 = '0, hold0 = '0;
    logic [31:0] mdl [int];
    logic        res_v = 1'b0;
    int          res_idx = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(W2)) dut (
        .clk(clk), .rst(rst),
        .data_addr_i(addr), .data_data_i(wdata), .data_sel_i(sel),
        .data_we_i(we), .data_rd_i(rd), .mem_fc_i(fc), .mem_sc_i(sc),
        .data_data_o(rdata), .data_valid_o(valid), .data_err_o(err)
    );

    data_mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .data_addr_i(addr0), .data_data_i(wdata0), .data_sel_i(sel0),
        .data_we_i(we0), .data_rd_i(rd0), .mem_fc_i(tie0), .mem_sc_i(tie0),
        .data_data_o(rdata0), .data_valid_o(valid0), .data_err_o(err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model of a store: size in bytes, must be size-aligned, lanes from addr.
    function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] s, input logic en, output logic merr);
        int          nbytes;
        int          lo;
        int          idx;
        logic [31:0] word;
        nbytes = (s == 2'b10) ? 1 : (s == 2'b01) ? 2 : 4;
        lo     = int'(a[1:0]);
        idx    = int'(a[AB+1:2]);
        merr   = (lo % nbytes) != 0;
        word   = mdl.exists(idx) ? mdl[idx] : 32'd0;
        if (!merr && en) begin
            for (int b = 0; b < nbytes; b++) word[8*(lo+b) +: 8] = d[8*(lo+b) +: 8];
            mdl[idx] = word;
        end
    endfunction

    // Compare both instances every cycle against the predicted responses.
    always @(negedge clk) begin
        if (!rst) begin
            hold2 = 32'd0;
            hold0 = 32'd0;
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
            chk("rst_data", rdata, 32'd0);
            chk("rst_valid0", {31'd0, valid0}, 32'd0);
            chk("rst_data0", rdata0, 32'd0);
        end else begin
            if (q2.size() > 0 && q2[0].cyc == cyc) begin
                chk("valid_pulse", {31'd0, valid}, 32'd1);
                chk("resp_data", rdata, q2[0].data);
                chk("resp_err", {31'd0, err}, {31'd0, q2[0].err});
                hold2 = q2[0].data;
                void'(q2.pop_front());
            end else begin
                chk("valid_idle", {31'd0, valid}, 32'd0);
                chk("err_idle", {31'd0, err}, 32'd0);
                chk("data_hold", rdata, hold2);
            end
            if (q0.size() > 0 && q0[0].cyc == cyc) begin
                chk("valid0_pulse", {31'd0, valid0}, 32'd1);
                chk("resp0_data", rdata0, q0[0].data);
                chk("resp0_err", {31'd0, err0}, {31'd0, q0[0].err});
                hold0 = q0[0].data;
                void'(q0.pop_front());
            end else begin
                chk("valid0_idle", {31'd0, valid0}, 32'd0);
                chk("data0_hold", rdata0, hold0);
            end
        end
    end

    task automatic access(input logic w, input logic r, input logic f, input logic s_c,
                          input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input logic scramble, output logic [31:0] got, output logic gerr);
        exp_t e;
        logic merr;
        logic ok;
        int   idx;
        @(negedge clk);
        addr = a; wdata = d; sel = s; we = w; rd = r; fc = f; sc = s_c;
        idx   = int'(a[AB+1:2]);
        e.cyc = cyc + 1 + W2 + 1;
        e.err = 1'b0;
        if (w) begin
            ok = 1'b1;
`ifdef DMEM_LLSC_EN
            if (s_c) ok = res_v && (res_idx == idx);
`endif
            mdl_write(a, d, s, ok, merr);
            e.err  = merr;
            e.data = 32'd1;
`ifdef DMEM_LLSC_EN
            if (s_c) begin
                e.data = {31'd0, ok && !merr};
                res_v  = 1'b0;
            end else if (!merr && res_v && res_idx == idx) begin
                res_v = 1'b0;
            end
`endif
        end else begin
            e.data = mdl[idx];
`ifdef DMEM_LLSC_EN
            if (f) begin
                res_v   = 1'b1;
                res_idx = idx;
            end
`endif
        end
        q2.push_back(e);
        @(posedge clk);
        if (scramble) begin
            #1;
            addr = ~a; wdata = ~d; sel = ~s; fc = ~f; sc = ~s_c;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid) break;
        end
        chk("resp_arrived", {31'd0, valid}, 32'd1);
        got  = rdata;
        gerr = err;
        we = 1'b0; rd = 1'b0; fc = 1'b0; sc = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic        gerr;
        exp_t        e;
        int          c0;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Basic read latency and data.
        access(1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 2'b00, 0, got, gerr);
        access(0, 1, 0, 0, 32'h10, 32'h0, 2'b00, 0, got, gerr);
        chk("rd_deadbeef", got, 32'hDEADBEEF);

        // Lane merges.
        access(1, 0, 0, 0, 32'h10, 32'h11223344, 2'b00, 0, got, gerr);
        access(1, 0, 0, 0, 32'h13, 32'hAA000000, 2'b10, 0, got, gerr);
        access(0, 1, 0, 0, 32'h10, 32'h0, 2'b00, 0, got, gerr);
        chk("byte_merge", got, 32'hAA223344);
        access(1, 0, 0, 0, 32'h12, 32'hBBCC0000, 2'b01, 0, got, gerr);
        access(0, 1, 0, 0, 32'h10, 32'h0, 2'b00, 0, got, gerr);
        chk("half_merge", got, 32'hBBCC3344);

        // Misaligned writes.
        access(1, 0, 0, 0, 32'h20, 32'h55667788, 2'b00, 0, got, gerr);
        access(1, 0, 0, 0, 32'h21, 32'h00FFFF00, 2'b01, 0, got, gerr);
        chk("half_misalign_err", {31'd0, gerr}, 32'd1);
        access(1, 0, 0, 0, 32'h22, 32'h99999999, 2'b00, 0, got, gerr);
        chk("word_misalign_err", {31'd0, gerr}, 32'd1);
        access(0, 1, 0, 0, 32'h20, 32'h0, 2'b00, 0, got, gerr);
        chk("misalign_unchanged", got, 32'h55667788);

        // sel=11 as word, byte lane 1, rd+we treated as write.
        access(1, 0, 0, 0, 32'h24, 32'h0BADF00D, 2'b11, 0, got, gerr);
        access(1, 0, 0, 0, 32'h25, 32'h00005A00, 2'b10, 0, got, gerr);
        access(0, 1, 0, 0, 32'h24, 32'h0, 2'b00, 0, got, gerr);
        chk("byte_lane1", got, 32'h0BAD5A0D);
        access(1, 1, 0, 0, 32'h28, 32'h13572468, 2'b00, 0, got, gerr);
        access(0, 1, 0, 0, 32'h28, 32'h0, 2'b00, 0, got, gerr);
        chk("rdwe_is_write", got, 32'h13572468);

        // Inputs changed during WAIT, misaligned read, upper address bits.
        access(0, 1, 0, 0, 32'h10, 32'h0, 2'b00, 1, got, gerr);
        chk("scrambled_read", got, 32'hBBCC3344);
        access(0, 1, 0, 0, 32'h13, 32'h0, 2'b10, 0, got, gerr);
        access(0, 1, 0, 0, 32'hFFFFF010, 32'h0, 2'b00, 0, got, gerr);
        chk("upper_addr_ignored", got, 32'hBBCC3344);

`ifdef DMEM_LLSC_EN
        access(1, 0, 0, 0, 32'h40, 32'h0, 2'b00, 0, got, gerr);
        access(0, 1, 1, 0, 32'h40, 32'h0, 2'b00, 0, got, gerr);
        access(1, 0, 0, 1, 32'h40, 32'h5, 2'b00, 0, got, gerr);
        chk("sc_success", got, 32'd1);
        access(0, 1, 0, 0, 32'h40, 32'h0, 2'b00, 0, got, gerr);
        chk("sc_wrote", got, 32'd5);
        access(0, 1, 1, 0, 32'h40, 32'h0, 2'b00, 0, got, gerr);
        access(1, 0, 0, 0, 32'h40, 32'h9, 2'b00, 0, got, gerr);
        access(1, 0, 0, 1, 32'h40, 32'h7, 2'b00, 0, got, gerr);
        chk("sc_fail", got, 32'd0);
        access(0, 1, 0, 0, 32'h40, 32'h0, 2'b00, 0, got, gerr);
        chk("sc_no_write", got, 32'd9);
`else
        access(1, 0, 0, 1, 32'h28, 32'h2468ACE0, 2'b00, 0, got, gerr);
        chk("sc_plain_status", got, 32'd1);
        access(0, 1, 1, 0, 32'h28, 32'h0, 2'b00, 0, got, gerr);
        chk("sc_plain_store", got, 32'h2468ACE0);
`endif

        // Reset during WAIT of a write aborts it.
        access(1, 0, 0, 0, 32'h30, 32'h12345678, 2'b00, 0, got, gerr);
        @(negedge clk);
        addr = 32'h30; wdata = 32'h77; sel = 2'b00; we = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        we  = 1'b0;
        res_v = 1'b0;
        q2.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        access(0, 1, 0, 0, 32'h30, 32'h0, 2'b00, 0, got, gerr);
        chk("reset_abort_unchanged", got, 32'h12345678);

        // WAIT_CYCLES=0 with a held write: a pulse every second cycle.
        @(negedge clk);
        addr0 = 32'h8; wdata0 = 32'hCAFEF00D; sel0 = 2'b00; we0 = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
            e.cyc = c0 + 2 + 2 * k; e.data = 32'd1; e.err = 1'b0;
            q0.push_back(e);
        end
        for (int k = 0; k < 40 && cyc < c0 + 12; k++) @(negedge clk);
        we0 = 1'b0;
        @(negedge clk);
        addr0 = 32'h8; rd0 = 1'b1;
        e.cyc = cyc + 2; e.data = 32'hCAFEF00D; e.err = 1'b0;
        q0.push_back(e);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid0) break;
        end
        chk("w0_read_arrived", {31'd0, valid0}, 32'd1);
        chk("w0_read_data", rdata0, 32'hCAFEF00D);
        rd0 = 1'b0;

        repeat (4) @(negedge clk);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
